// File: rtl/pipeline_types_pkg.sv
// pipeline_types_pkg: pass record carried around the thread ring.
package pipeline_types_pkg;
  typedef struct packed {
    logic       active_thread;
    logic [7:0] id;
    logic [7:0] thread;
  } system_t;
  typedef struct packed {
    system_t     system;
    logic [31:0] data;
    logic [31:0] shared;
  } pipeline_pass_structure;
endpackage

// File: rtl/recirc_pkg.sv
// recirc_pkg: head-select encoding and live counter sizing for the recirculator.
package recirc_pkg;
  typedef enum logic [1:0] {SEL_RECIRC, SEL_HOST, SEL_BUBBLE} head_sel_e;
  function automatic int live_w(input int max_live);
    return $clog2(max_live + 1);
  endfunction
endpackage

// File: rtl/recirc_fifo.sv
// recirc_fifo: synchronous FIFO of pass records with wrap-bit pointers.
module recirc_fifo
  import pipeline_types_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  pipeline_pass_structure       din,
  output pipeline_pass_structure       dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  pipeline_pass_structure mem [DEPTH];
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign count = wp - rp;
  assign dout  = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && push && !full) mem[wp[AW-1:0]] <= din;
  end
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));
endmodule

// File: rtl/thread_recirculator.sv
// thread_recirculator: retires or recirculates tail threads and fills head bubbles with host threads.
module thread_recirculator
  import pipeline_types_pkg::*, recirc_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int MAX_LIVE = DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  pipeline_pass_structure         tail_in,
  input  logic                           tail_retire,
  input  logic                           host_valid,
  input  pipeline_pass_structure         host_in,
  output logic                           host_ready,
  output pipeline_pass_structure         head_out,
  output logic                           ret_valid,
  output pipeline_pass_structure         ret_out,
  output logic [live_w(MAX_LIVE)-1:0]    live_count,
  output logic                           ovf_err
);
  localparam int LW = live_w(MAX_LIVE);
  localparam logic [LW-1:0] MAXL = LW'(MAX_LIVE);
  logic push, pop, retire, full, empty;
  logic [$clog2(DEPTH+1)-1:0] occ;
  logic [LW-1:0] live_next;
  pipeline_pass_structure fifo_dout;
  head_sel_e sel;
  assign retire = tail_in.system.active_thread && tail_retire;
  assign push   = tail_in.system.active_thread && !tail_retire;
  // admission looks only at the registered count, so a retire frees budget one cycle later
  assign sel = !empty ? SEL_RECIRC
             : (host_valid && live_count < MAXL && !rst) ? SEL_HOST : SEL_BUBBLE;
  assign pop        = sel == SEL_RECIRC;
  assign host_ready = sel == SEL_HOST;
  assign live_next = (host_ready && !retire && live_count != MAXL) ? live_count + 1'b1
                   : (retire && !host_ready && live_count != '0) ? live_count - 1'b1
                   : live_count;
  recirc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(tail_in),
    .dout(fifo_dout), .full(full), .empty(empty), .count(occ)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      head_out   <= '0;
      ret_out    <= '0;
      ret_valid  <= 1'b0;
      live_count <= '0;
      ovf_err    <= 1'b0;
    end else begin
      head_out   <= sel == SEL_RECIRC ? fifo_dout : sel == SEL_HOST ? host_in : '0;
      ret_valid  <= retire;
      if (retire) ret_out <= tail_in;
      if (push && full) ovf_err <= 1'b1;
      live_count <= live_next;
    end
  end
  a_ready_budget: assert property (@(posedge clk) disable iff (rst) host_ready |-> live_count < MAXL);
  a_bubble_zero:  assert property (@(posedge clk) disable iff (rst) !head_out.system.active_thread |-> head_out == '0);
  a_no_under:     assert property (@(posedge clk) disable iff (rst) !(retire && !host_ready && live_count == '0));
  a_no_over:      assert property (@(posedge clk) disable iff (rst) !(host_ready && !retire && live_count == MAXL));
  a_occ_budget:   assert property (@(posedge clk) disable iff (rst) occ <= ($clog2(DEPTH+1))'(MAX_LIVE));
endmodule

// File: tb/tb_thread_recirculator.sv
// tb_thread_recirculator: table vectors plus a queue model scoreboard for the recirculator.
module tb_thread_recirculator;
  import pipeline_types_pkg::*;
  localparam int DEPTH = 8;
  localparam int ML = 8;
  localparam int LW = $clog2(ML + 1);
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tail_retire = 1'b0, host_valid = 1'b0;
  logic host_ready, ret_valid, ovf_err;
  pipeline_pass_structure tail_in = '0, host_in = '0, head_out, ret_out;
  logic [LW-1:0] live_count;
  always #5 clk = ~clk;
  thread_recirculator #(.DEPTH(DEPTH), .MAX_LIVE(ML)) dut (
    .clk(clk), .rst(rst), .tail_in(tail_in), .tail_retire(tail_retire),
    .host_valid(host_valid), .host_in(host_in), .host_ready(host_ready),
    .head_out(head_out), .ret_valid(ret_valid), .ret_out(ret_out),
    .live_count(live_count), .ovf_err(ovf_err)
  );
  typedef struct {
    logic chk_head;
    pipeline_pass_structure head;
    logic ret_v;
    pipeline_pass_structure ret;
    int live;
    logic ovf;
  } exp_t;
  typedef struct {
    int id;
    logic rdy;
    int live;
  } vec_t;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  pipeline_pass_structure m_q[$];
  int m_live = 0;
  logic m_ovf = 1'b0;
  logic nopop = 1'b0;
  pipeline_pass_structure m_ret = '0;
  localparam pipeline_pass_structure NONE = '0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic pipeline_pass_structure mk(input int id);
    pipeline_pass_structure r;
    r.system.active_thread = 1'b1;
    r.system.id = 8'(id);
    r.system.thread = 8'(id + 100);
    r.data = 32'h01010101 * 32'(id) + 32'h5a;
    r.shared = ~r.data;
    return r;
  endfunction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk_head) chk("head_out", 128'(head_out), 128'(e.head));
        chk("ret_valid", 128'(ret_valid), 128'(e.ret_v));
        chk("ret_out", 128'(ret_out), 128'(e.ret));
        chk("live_count", 128'(live_count), 128'(e.live));
        chk("ovf_err", 128'(ovf_err), 128'(e.ovf));
      end
    end
  end
  task automatic cyc(input pipeline_pass_structure t, input logic r, input logic hv,
                     input pipeline_pass_structure h);
    exp_t e;
    logic exp_hr, full, act;
    @(negedge clk);
    rst = 1'b0;
    tail_in = t;
    tail_retire = r;
    host_valid = hv;
    host_in = h;
    #1;
    full = m_q.size() >= DEPTH;
    act = t.system.active_thread;
    exp_hr = 1'b0;
    e.head = '0;
    if (m_q.size() > 0) begin
      if (nopop) e.head = m_q[0];
      else e.head = m_q.pop_front();
    end else if (hv && m_live < ML) begin
      exp_hr = 1'b1;
      e.head = h;
    end
    chk("host_ready", 128'(host_ready), 128'(exp_hr));
    if (act && r) m_ret = t;
    else if (act && full) m_ovf = 1'b1;
    else if (act) m_q.push_back(t);
    if (exp_hr && !(act && r)) m_live++;
    else if (act && r && !exp_hr && m_live > 0) m_live--;
    e.chk_head = !nopop;
    e.ret_v = act && r;
    e.ret = m_ret;
    e.live = m_live;
    e.ovf = m_ovf;
    sb.push_back(e);
  endtask
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1;
      host_valid = 1'b1;
      host_in = mk(99);
      tail_in = '0;
      tail_retire = 1'b0;
      #1;
      chk("rst host_ready", 128'(host_ready), 128'(0));
      @(posedge clk);
      #2;
      chk("rst head_out", 128'(head_out), 128'(0));
      chk("rst live_count", 128'(live_count), 128'(0));
      chk("rst ret_valid", 128'(ret_valid), 128'(0));
      chk("rst ret_out", 128'(ret_out), 128'(0));
      chk("rst ovf_err", 128'(ovf_err), 128'(0));
    end
    m_q.delete();
    m_live = 0;
    m_ovf = 1'b0;
    m_ret = '0;
  endtask
  initial begin
    vec_t tv[10];
    tv = '{'{0, 1'b1, 1}, '{1, 1'b1, 2}, '{2, 1'b1, 3}, '{3, 1'b1, 4}, '{4, 1'b1, 5},
           '{5, 1'b1, 6}, '{6, 1'b1, 7}, '{7, 1'b1, 8}, '{8, 1'b0, 8}, '{9, 1'b0, 8}};
    do_reset(3);
    cyc(NONE, 1'b0, 1'b1, mk(1));
    @(posedge clk);
    #2;
    chk("first host id", 128'(head_out.system.id), 128'(1));
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      cyc(NONE, 1'b0, 1'b1, mk(tv[i].id));
      chk("tbl host_ready", 128'(host_ready), 128'(tv[i].rdy));
      @(posedge clk);
      #2;
      chk("tbl live_count", 128'(live_count), 128'(tv[i].live));
    end
    cyc(mk(3), 1'b0, 1'b1, mk(9));
    cyc(NONE, 1'b0, 1'b1, mk(9));
    chk("recirc host_ready", 128'(host_ready), 128'(0));
    @(posedge clk);
    #2;
    chk("recirc head id", 128'(head_out.system.id), 128'(3));
    cyc(NONE, 1'b0, 1'b1, mk(9));
    cyc(mk(5), 1'b1, 1'b1, mk(9));
    chk("retire host_ready", 128'(host_ready), 128'(0));
    @(posedge clk);
    #2;
    chk("ret id", 128'(ret_out.system.id), 128'(5));
    chk("ret live", 128'(live_count), 128'(7));
    cyc(NONE, 1'b0, 1'b1, mk(9));
    chk("post-retire host_ready", 128'(host_ready), 128'(1));
    for (int i = 0; i < 20; i++) cyc(mk(20 + i), 1'b0, 1'b0, NONE);
    cyc(NONE, 1'b0, 1'b0, NONE);
    cyc(NONE, 1'b0, 1'b0, NONE);
    @(posedge clk);
    #2;
    chk("wrap ovf_err", 128'(ovf_err), 128'(0));
    do_reset(1);
    force dut.pop = 1'b0;
    nopop = 1'b1;
    for (int i = 0; i < 9; i++) cyc(mk(40 + i), 1'b0, 1'b0, NONE);
    @(posedge clk);
    #2;
    chk("ovf set", 128'(ovf_err), 128'(1));
    release dut.pop;
    nopop = 1'b0;
    for (int i = 0; i < 10; i++) cyc(NONE, 1'b0, 1'b0, NONE);
    @(posedge clk);
    #2;
    chk("ovf sticky", 128'(ovf_err), 128'(1));
    do_reset(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
